// File: rtl/fmul_arb.sv
// fmul_arb: two-port round-robin arbiter in front of one shared fmul with a fixed LAT-cycle latency.
// Each port owns a one-entry result slot, and a full slot blocks only that port.
module fmul_arb #(
    parameter int unsigned LAT = 6
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        a_valid_i,
    output logic        a_ready_o,
    input  logic [31:0] a_x_i,
    input  logic [31:0] a_y_i,
    output logic        a_rvalid_o,
    input  logic        a_rready_i,
    output logic [31:0] a_rslt_o,
    output logic [4:0]  a_flag_o,
    input  logic        b_valid_i,
    output logic        b_ready_o,
    input  logic [31:0] b_x_i,
    input  logic [31:0] b_y_i,
    output logic        b_rvalid_o,
    input  logic        b_rready_i,
    output logic [31:0] b_rslt_o,
    output logic [4:0]  b_flag_o,
    output logic        m_req_o,
    output logic [31:0] m_x_o,
    output logic [31:0] m_y_o,
    input  logic [31:0] m_rslt_i,
    input  logic [4:0]  m_flag_i,
    output logic        busy_o
);
    typedef enum logic [1:0] {IDLE, ISSUE, RUN} state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic        ptr_q, own_q, m_req_q;
    logic [31:0] mx_q, my_q, a_rslt_q, b_rslt_q;
    logic [4:0]  a_flag_q, b_flag_q;
    logic        a_rvalid_q, b_rvalid_q;
    logic        elig_a, elig_b, gnt_a, gnt_b, done;

    // ptr_q=1 means B was granted last, so A wins a tie
    assign elig_a = a_valid_i & ~a_rvalid_q;
    assign elig_b = b_valid_i & ~b_rvalid_q;
    assign gnt_a  = (state_q == IDLE) & elig_a & (~elig_b | ptr_q);
    assign gnt_b  = (state_q == IDLE) & elig_b & (~elig_a | ~ptr_q);
    assign done   = (state_q == RUN) & (cnt_q == 4'd1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            ptr_q      <= 1'b1;
            own_q      <= 1'b0;
            m_req_q    <= 1'b0;
            mx_q       <= 32'd0;
            my_q       <= 32'd0;
            a_rslt_q   <= 32'd0;
            b_rslt_q   <= 32'd0;
            a_flag_q   <= 5'd0;
            b_flag_q   <= 5'd0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
        end else begin
            m_req_q <= 1'b0;
            case (state_q)
                IDLE: if (gnt_a | gnt_b) begin
                    mx_q    <= gnt_a ? a_x_i : b_x_i;
                    my_q    <= gnt_a ? a_y_i : b_y_i;
                    own_q   <= gnt_b;
                    ptr_q   <= gnt_b;
                    m_req_q <= 1'b1;
                    state_q <= ISSUE;
                end
                ISSUE: begin
                    cnt_q   <= 4'(LAT);
                    state_q <= RUN;
                end
                RUN: begin
                    cnt_q   <= cnt_q - 4'd1;
                    state_q <= done ? IDLE : RUN;
                end
                default: state_q <= IDLE;
            endcase
            a_rvalid_q <= (done & ~own_q) | (a_rvalid_q & ~a_rready_i);
            b_rvalid_q <= (done & own_q) | (b_rvalid_q & ~b_rready_i);
            if (done & ~own_q) begin
                a_rslt_q <= m_rslt_i;
                a_flag_q <= m_flag_i;
            end
            if (done & own_q) begin
                b_rslt_q <= m_rslt_i;
                b_flag_q <= m_flag_i;
            end
        end
    end

    assign a_ready_o  = gnt_a;
    assign b_ready_o  = gnt_b;
    assign a_rvalid_o = a_rvalid_q;
    assign b_rvalid_o = b_rvalid_q;
    assign a_rslt_o   = a_rslt_q;
    assign b_rslt_o   = b_rslt_q;
    assign a_flag_o   = a_flag_q;
    assign b_flag_o   = b_flag_q;
    assign m_req_o    = m_req_q;
    assign m_x_o      = mx_q;
    assign m_y_o      = my_q;
    assign busy_o     = state_q != IDLE;
endmodule

// File: tb/tb_fmul_arb.sv
// tb_fmul_arb: directed bench for fmul_arb with a table-driven fmul that answers only in its final cycle.
module tb_fmul_arb;
    localparam int LAT = 6;

    logic        clk_i = 1'b0, rst_ni = 1'b0;
    logic        a_valid_i = 1'b0, a_rready_i = 1'b0, b_valid_i = 1'b0, b_rready_i = 1'b0;
    logic [31:0] a_x_i = '0, a_y_i = '0, b_x_i = '0, b_y_i = '0;
    logic        a_ready_o, b_ready_o, a_rvalid_o, b_rvalid_o, m_req_o, busy_o;
    logic [31:0] a_rslt_o, b_rslt_o, m_x_o, m_y_o, m_rslt_i;
    logic [4:0]  a_flag_o, b_flag_o, m_flag_i;
    int          k = 31;
    int          checks = 0, errors = 0, bad;
    logic [31:0] sx, sy;

    fmul_arb #(.LAT(LAT)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .a_valid_i(a_valid_i), .a_ready_o(a_ready_o), .a_x_i(a_x_i), .a_y_i(a_y_i),
        .a_rvalid_o(a_rvalid_o), .a_rready_i(a_rready_i), .a_rslt_o(a_rslt_o), .a_flag_o(a_flag_o),
        .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_x_i(b_x_i), .b_y_i(b_y_i),
        .b_rvalid_o(b_rvalid_o), .b_rready_i(b_rready_i), .b_rslt_o(b_rslt_o), .b_flag_o(b_flag_o),
        .m_req_o(m_req_o), .m_x_o(m_x_o), .m_y_o(m_y_o), .m_rslt_i(m_rslt_i), .m_flag_i(m_flag_i),
        .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    // k counts cycles since m_req; the fake fmul answers only when k==LAT
    always_ff @(posedge clk_i) k <= m_req_o ? 1 : (k < 31 ? k + 1 : 31);

    function automatic logic [36:0] fm(input logic [31:0] x, input logic [31:0] y);
        if ((x == 32'h3FC00000 && y == 32'h40000000) || (x == 32'h40000000 && y == 32'h3FC00000))
            return {5'b00000, 32'h40400000};
        if (x == 32'h7F800000 && y == 32'h00000000) return {5'b10000, 32'hFFC00000};
        if (x == 32'h7F800001) return {5'b10000, 32'h7FC00001};
        return {5'b00000, 32'hDEADBEEF};
    endfunction

    assign {m_flag_i, m_rslt_i} = (k == LAT) ? fm(m_x_o, m_y_o) : {5'h1F, 32'h0BADF00D};

    task automatic nxt();
        @(posedge clk_i);
        #1;
    endtask

    task automatic ck(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk_i);
        #1;
        ck("rst_busy", 32'(busy_o), 0);
        ck("rst_mreq", 32'(m_req_o), 0);
        ck("rst_mx", m_x_o, 0);
        ck("rst_my", m_y_o, 0);
        ck("rst_arvalid", 32'(a_rvalid_o), 0);
        ck("rst_brvalid", 32'(b_rvalid_o), 0);
        ck("rst_rslt", a_rslt_o | b_rslt_o, 0);
        ck("rst_flag", 32'(a_flag_o | b_flag_o), 0);
        rst_ni = 1'b1;
        nxt();
        // first tie after reset: A wins, B follows when the fmul frees up
        a_valid_i = 1; a_x_i = 32'h3FC00000; a_y_i = 32'h40000000;
        b_valid_i = 1; b_x_i = 32'h7F800000; b_y_i = 32'h00000000;
        #2;
        ck("tie1_aready", 32'(a_ready_o), 1);
        ck("tie1_bready", 32'(b_ready_o), 0);
        nxt(); a_valid_i = 0; #2;
        ck("tie1_mreq", 32'(m_req_o), 1);
        ck("tie1_mx", m_x_o, 32'h3FC00000);
        ck("tie1_busy", 32'(busy_o), 1);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            nxt(); #2;
            if (a_rvalid_o || m_req_o || b_ready_o || b_rvalid_o) bad++;
        end
        ck("tie1_quiet", 32'(bad), 0);
        nxt(); a_rready_i = 1; #2;
        ck("a_rvalid_t8", 32'(a_rvalid_o), 1);
        ck("a_rslt", a_rslt_o, 32'h40400000);
        ck("a_flag", 32'(a_flag_o), 0);
        ck("tie1_bgrant", 32'(b_ready_o), 1);
        ck("idle_busy", 32'(busy_o), 0);
        nxt(); a_rready_i = 0; b_valid_i = 0; #2;
        ck("a_slot_clr", 32'(a_rvalid_o), 0);
        ck("b_mreq", 32'(m_req_o), 1);
        ck("b_mx", m_x_o, 32'h7F800000);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            nxt(); #2;
            if (b_rvalid_o) bad++;
        end
        ck("b_quiet", 32'(bad), 0);
        nxt(); b_rready_i = 1; #2;
        ck("b_rvalid_inf0", 32'(b_rvalid_o), 1);
        ck("b_rslt_inf0", b_rslt_o, 32'hFFC00000);
        ck("b_flag_inf0", 32'(b_flag_o), 32'h10);
        nxt(); b_rready_i = 0;
        // second tie: pointer is B, so A wins again; A operands scrambled after acceptance
        a_valid_i = 1; a_x_i = 32'h3FC00000; a_y_i = 32'h40000000;
        b_valid_i = 1; b_x_i = 32'h7F800001; b_y_i = 32'h3F800000;
        #2;
        ck("tie2_aready", 32'(a_ready_o), 1);
        ck("tie2_bready", 32'(b_ready_o), 0);
        nxt(); a_valid_i = 0; a_x_i = $urandom; a_y_i = $urandom; #2;
        sx = m_x_o; sy = m_y_o;
        ck("tie2_mx", sx, 32'h3FC00000);
        ck("tie2_my", sy, 32'h40000000);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            nxt(); a_x_i = $urandom; a_y_i = $urandom; #2;
            if (m_x_o !== sx || m_y_o !== sy) bad++;
        end
        ck("operand_stable", 32'(bad), 0);
        nxt(); #2;
        ck("tie2_arvalid", 32'(a_rvalid_o), 1);
        ck("tie2_arslt", a_rslt_o, 32'h40400000);
        ck("tie2_bgrant", 32'(b_ready_o), 1);
        nxt(); b_valid_i = 0;
        repeat (6) nxt();
        nxt(); b_rready_i = 1; #2;
        ck("snan_rslt", b_rslt_o, 32'h7FC00001);
        ck("snan_flag4", 32'(b_flag_o[4]), 1);
        ck("a_slot_kept", 32'(a_rvalid_o), 1);
        ck("a_rslt_kept", a_rslt_o, 32'h40400000);
        nxt(); b_rready_i = 0;
        // backpressure: A slot full, so only B may be granted
        a_valid_i = 1; a_x_i = 32'h7F800000; a_y_i = 32'h00000000;
        b_valid_i = 1; b_x_i = 32'h40000000; b_y_i = 32'h3FC00000;
        #2;
        ck("bp_aready", 32'(a_ready_o), 0);
        ck("bp_bready", 32'(b_ready_o), 1);
        nxt(); b_valid_i = 0;
        repeat (6) nxt();
        nxt(); #2;
        ck("bp_brslt", b_rslt_o, 32'h40400000);
        ck("bp_idle_ablk", 32'(a_ready_o), 0);
        a_rready_i = 1; b_rready_i = 1; #1;
        ck("bp_clr_same_cyc", 32'(a_ready_o), 0);
        nxt(); a_rready_i = 0; b_rready_i = 0; #2;
        ck("bp_a_cleared", 32'(a_rvalid_o), 0);
        ck("bp_a_grant", 32'(a_ready_o), 1);
        nxt(); a_valid_i = 0; #2;
        ck("rr_mreq", 32'(m_req_o), 1);
        ck("rr_mx", m_x_o, 32'h7F800000);
        // reset 3 cycles after m_req abandons the op
        nxt(); nxt(); nxt();
        rst_ni = 0; #2;
        ck("mid_rst_busy", 32'(busy_o), 0);
        ck("mid_rst_mx", m_x_o, 0);
        nxt(); rst_ni = 1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            nxt(); #2;
            if (m_req_o || a_rvalid_o || b_rvalid_o || busy_o) bad++;
        end
        ck("post_rst_quiet", 32'(bad), 0);
        nxt();
        a_valid_i = 1; a_x_i = 32'h3FC00000; a_y_i = 32'h40000000; #2;
        ck("post_rst_aready", 32'(a_ready_o), 1);
        nxt(); a_valid_i = 0; #2;
        ck("post_rst_mreq", 32'(m_req_o), 1);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            nxt(); #2;
            if (a_rvalid_o || m_req_o) bad++;
        end
        ck("post_rst_quiet2", 32'(bad), 0);
        nxt(); #2;
        ck("post_rst_arvalid", 32'(a_rvalid_o), 1);
        ck("post_rst_arslt", a_rslt_o, 32'h40400000);
        ck("post_rst_aflag", 32'(a_flag_o), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fmul_arb.md
FMUL_ARB -- requirements
Module: fmul_arb

Interface
REQ-001 The block SHALL have parameter LAT, default 6, meaning the number of cycles from the fmul_req pulse to the fmul result being valid; legal range 2..15.
REQ-002 The block SHALL have a single clock and a reset that is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 a_valid / b_valid  input  1  requester A/B operation request.
REQ-006 a_ready / b_ready  output  1  requester A/B request accepted this cycle.
REQ-007 a_x, a_y / b_x, b_y  input  32  requester A/B IEEE-754 single operands.
REQ-008 a_rvalid / b_rvalid  output  1  result held for requester A/B.
REQ-009 a_rready / b_rready  input  1  requester A/B consumes its result.
REQ-010 a_rslt / b_rslt  output  32  product for requester A/B.
REQ-011 a_flag / b_flag  output  5  exception flags for requester A/B, bit layout identical to fmul flag.
REQ-012 m_req  output  1  one-cycle start pulse to the shared fmul.
REQ-013 m_x, m_y  output  32  operands to the fmul.
REQ-014 m_rslt  input  32  fmul result.
REQ-015 m_flag  input  5  fmul flags.
REQ-016 busy  output  1  operation outstanding (state not IDLE).

Function
REQ-017 The block SHALL implement states IDLE, ISSUE and RUN, with at most one fmul operation outstanding.
REQ-018 Port p SHALL be eligible when p_valid=1 and p_rvalid=0; a full result slot blocks that port only.
REQ-019 In IDLE, the block SHALL grant exactly one eligible port per cycle.
- Only one eligible: grant it.
- Both eligible: grant the port not granted last (round-robin pointer).
REQ-020 p_ready SHALL be 1 only in IDLE for the granted port; it may depend combinationally on the valids and result-slot states.
REQ-021 On handshake (p_valid & p_ready), at the clock edge:
- latch p_x/p_y into m_x/m_y;
- record the owner;
- update the pointer to p;
- go to ISSUE.
REQ-022 In ISSUE, m_req SHALL be 1 for exactly one cycle; the block loads a countdown counter with LAT and goes to RUN.
REQ-023 In RUN, the counter SHALL decrement each cycle.
REQ-024 When the counter reaches 1, the block SHALL capture m_rslt/m_flag into the owner's result slot at that edge, set the owner's rvalid, and return to IDLE.
REQ-025 m_x/m_y SHALL remain stable from the handshake edge until the capture edge, because the fmul reads its operands in its final stage.
REQ-026 Latency: with the handshake in cycle T, m_req is high in T+1 and rvalid is first high in T+2+LAT (T+8 for LAT=6).
REQ-027 The earliest next handshake SHALL be in cycle T+2+LAT, giving a throughput of 1 op per LAT+2 cycles.
REQ-028 A result slot SHALL hold rslt/flag and rvalid until p_rvalid & p_rready; the slot clears at that edge.
REQ-029 A slot clear and a new grant to the same port in the same cycle SHALL NOT occur: eligibility uses the registered rvalid.
REQ-030 A capture into one port's slot SHALL never overwrite the other port's slot, and rvalid of the other port SHALL be unaffected.
REQ-031 valid deasserting before the handshake SHALL have no effect; the operands are sampled only at the handshake.
REQ-032 The round-robin pointer SHALL change only on a handshake.

Reset
REQ-033 While reset=0, the block SHALL force:
- state=IDLE, counter=0;
- m_req=0, m_x=0, m_y=0;
- a_rvalid=b_rvalid=0, a/b rslt=0, a/b flag=0;
- busy=0;
- pointer=B, so A wins the first tie.
REQ-034 Reset asserted mid-operation SHALL abandon the operation with no result delivered; after release, the next m_req restarts the fmul.
REQ-035 The block SHALL drive no spurious m_req after release.

Verification
REQ-036 Single op: A requests x=0x3FC00000, y=0x40000000 in cycle T -> m_req high in T+1, a_rvalid in T+8, a_rslt=0x40400000, a_flag=0.
REQ-037 Tie after reset: A and B valid together in the same cycle -> A granted first, then B; B's result 8 cycles after B's handshake. Next tie -> A again (pointer=B after the B grant).
REQ-038 Backpressure: A result pending with a_rready=0, A and B both valid -> only B is granted; A is granted only after a_rready clears the slot.
REQ-039 Exceptions: B sends x=0x7F800000, y=0x00000000 -> b_rslt=0xFFC00000, b_flag=5'b10000. B sends an sNaN (x=0x7F800001) -> b_rslt=0x7FC00001, b_flag[4]=1.
REQ-040 Reset mid-RUN: reset pulsed 3 cycles after m_req -> no rvalid appears; the next A request completes normally with the correct product.
REQ-041 Operand stability: the bench changes a_x/a_y every cycle after the handshake -> m_x/m_y remain constant until capture, and the result matches the accepted operands.
